// File: rtl/spi_msg_responder_if.sv
// rtl/spi_msg_responder_if.sv - SPI bus and core message/response signals of the responder
`timescale 1ns/1ps
interface spi_msg_responder_if #(
  parameter int MSG_LEN  = 4,
  parameter int RESP_LEN = 4
);
  logic                    spi_clk;
  logic                    spi_cs_n;
  logic [7:0]              spi_d_in;
  logic [7:0]              spi_d_out;
  logic                    spi_d_oe;
  logic                    msg_valid;
  logic                    msg_ready;
  logic [8*MSG_LEN-1:0]    msg_data;
  logic                    resp_valid;
  logic [8*RESP_LEN-1:0]   resp_data;
  logic                    abort;

  modport slave (
    input  spi_clk, spi_cs_n, spi_d_in, msg_ready, resp_valid, resp_data,
    output spi_d_out, spi_d_oe, msg_valid, msg_data, abort
  );

  modport master (
    output spi_clk, spi_cs_n, spi_d_in, msg_ready, resp_valid, resp_data,
    input  spi_d_out, spi_d_oe, msg_valid, msg_data, abort
  );
endinterface

// File: rtl/spi_msg_responder.sv
// rtl/spi_msg_responder.sv - oversampled SPI responder: collects a command message, returns the core's response
`timescale 1ns/1ps
module spi_msg_responder #(
  parameter int         MSG_LEN   = 4,
  parameter int         RESP_LEN  = 4,
  parameter logic [7:0] MARKER    = 8'hA5,
  parameter logic [7:0] BUSY_BYTE = 8'h00,
  parameter logic [7:0] FILL_BYTE = 8'hFF
) (
  input logic               clk,
  input logic               rst_n,
  spi_msg_responder_if.slave bus
);
  localparam int RXW = $clog2(MSG_LEN + 1);
  localparam int TXW = $clog2(RESP_LEN + 1);
  localparam logic [RXW-1:0] RX_LAST = RXW'(MSG_LEN - 1);
  localparam logic [TXW-1:0] TX_LAST = TXW'(RESP_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RX, S_MSG_WAIT, S_RESP_WAIT, S_TX_MARK, S_TX, S_DONE
  } state_t;

  state_t state, state_n;

  // spi_clk gets a third stage for edge detection; data keeps the same depth so it lines up with the edge
  logic [2:0]  clk_sync;
  logic [1:0]  cs_sync;
  logic [7:0]  d_s1, d_s2;
  logic        rise, fall, cs_high;

  logic [8*MSG_LEN-1:0]  rx_sr;
  logic [8*MSG_LEN+7:0]  rx_next;
  logic [8*RESP_LEN-1:0] tx_sr;
  logic [RXW-1:0]        rx_cnt;
  logic [TXW-1:0]        tx_cnt;
  logic [7:0]            d_out_q;
  logic                  oe_q, msg_valid_q, abort_q;

  logic       capture, msg_set, msg_clr, load_resp, drive, tx_shift, end_txn, abort_n;
  logic [7:0] drive_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= 3'b000;
      cs_sync  <= 2'b11;
      d_s1     <= 8'h00;
      d_s2     <= 8'h00;
    end else begin
      clk_sync <= {clk_sync[1:0], bus.spi_clk};
      cs_sync  <= {cs_sync[0], bus.spi_cs_n};
      d_s1     <= bus.spi_d_in;
      d_s2     <= d_s1;
    end
  end

  assign rise    = clk_sync[1] & ~clk_sync[2];
  assign fall    = ~clk_sync[1] & clk_sync[2];
  assign cs_high = cs_sync[1];
  assign rx_next = {rx_sr, d_s2};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n    = state;
    capture    = 1'b0;
    msg_set    = 1'b0;
    msg_clr    = 1'b0;
    load_resp  = 1'b0;
    drive      = 1'b0;
    drive_byte = BUSY_BYTE;
    tx_shift   = 1'b0;
    end_txn    = 1'b0;
    abort_n    = 1'b0;
    // Chip-select release outranks every edge and handshake seen in the same cycle
    if (state != S_IDLE && cs_high) begin
      state_n = S_IDLE;
      end_txn = 1'b1;
      abort_n = (state == S_RX && rx_cnt != '0) || state == S_MSG_WAIT ||
                state == S_RESP_WAIT || state == S_TX_MARK;
    end else begin
      case (state)
        S_IDLE: if (!cs_high) state_n = S_RX;
        S_RX: if (rise) begin
          capture = 1'b1;
          if (rx_cnt == RX_LAST) begin
            msg_set = 1'b1;
            state_n = S_MSG_WAIT;
          end
        end
        S_MSG_WAIT: begin
          drive = fall;
          if (msg_valid_q && bus.msg_ready) begin
            msg_clr = 1'b1;
            state_n = S_RESP_WAIT;
          end
        end
        S_RESP_WAIT: begin
          drive = fall;
          if (bus.resp_valid) begin
            load_resp = 1'b1;
            state_n   = S_TX_MARK;
          end
        end
        S_TX_MARK: if (fall) begin
          drive      = 1'b1;
          drive_byte = MARKER;
          state_n    = S_TX;
        end
        S_TX: if (fall) begin
          drive      = 1'b1;
          drive_byte = tx_sr[8*RESP_LEN-1 -: 8];
          tx_shift   = 1'b1;
          if (tx_cnt == TX_LAST) state_n = S_DONE;
        end
        S_DONE: if (fall) begin
          drive      = 1'b1;
          drive_byte = FILL_BYTE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sr       <= '0;
      tx_sr       <= '0;
      rx_cnt      <= '0;
      tx_cnt      <= '0;
      d_out_q     <= BUSY_BYTE;
      oe_q        <= 1'b0;
      msg_valid_q <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      abort_q <= abort_n;
      if (end_txn) begin
        oe_q        <= 1'b0;
        msg_valid_q <= 1'b0;
        rx_cnt      <= '0;
        tx_cnt      <= '0;
      end
      if (capture) begin
        rx_sr  <= rx_next[8*MSG_LEN-1:0];
        rx_cnt <= rx_cnt + 1'b1;
      end
      if (msg_set) begin
        msg_valid_q <= 1'b1;
        oe_q        <= 1'b1;
      end
      if (msg_clr)   msg_valid_q <= 1'b0;
      if (load_resp) tx_sr <= bus.resp_data;
      if (msg_set || drive) d_out_q <= drive_byte;
      if (tx_shift) begin
        tx_sr  <= tx_sr << 8;
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

  // rx_sr doubles as the message register: nothing shifts in once the message is complete
  assign bus.msg_data  = rx_sr;
  assign bus.msg_valid = msg_valid_q;
  assign bus.spi_d_out = d_out_q;
  assign bus.spi_d_oe  = oe_q;
  assign bus.abort     = abort_q;
endmodule

// File: tb/tb_spi_msg_responder.sv
// tb/tb_spi_msg_responder.sv - directed/randomised bench for spi_msg_responder against a byte-queue model
`timescale 1ns/1ps
module tb_spi_msg_responder;
  localparam int         MSG_LEN  = 4;
  localparam int         RESP_LEN = 4;
  localparam logic [7:0] MARKER   = 8'hA5;
  localparam logic [7:0] BUSY     = 8'h00;
  localparam logic [7:0] FILL     = 8'hFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_msg_responder_if #(.MSG_LEN(MSG_LEN), .RESP_LEN(RESP_LEN)) bus ();
  spi_msg_responder #(.MSG_LEN(MSG_LEN), .RESP_LEN(RESP_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int abort_cycles = 0;

  // Model of the response stream: BUSY until a response is accepted, then marker, bytes, fill
  logic [7:0] tx_q[$];
  bit         resp_loaded;

  always @(negedge clk) if (bus.abort === 1'b1) abort_cycles++;

  initial begin
    #2ms;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] model_fall();
    if (!resp_loaded) return BUSY;
    if (tx_q.size() > 0) return tx_q.pop_front();
    return FILL;
  endfunction

  // One SPI bit period: fall, data change one clk later, rise; d_out is sampled just before the rise
  task automatic spi_cycle(input logic [7:0] b, input int lo, input int hi,
                           output logic [7:0] dq, output logic oq);
    bus.spi_clk = 1'b0;
    tick(1);
    bus.spi_d_in = b;
    tick(lo - 1);
    dq = bus.spi_d_out;
    oq = bus.spi_d_oe;
    bus.spi_clk = 1'b1;
    tick(hi);
  endtask

  task automatic close_cs(input int exp_abort, input string tag);
    int a0;
    a0 = abort_cycles;
    bus.spi_cs_n = 1'b1;
    tick(6);
    chk({tag, "_abort"}, abort_cycles - a0, exp_abort);
    chk({tag, "_oe"}, bus.spi_d_oe, 1'b0);
    chk({tag, "_msg_valid"}, bus.msg_valid, 1'b0);
    bus.spi_clk = 1'b0;
    tick(4);
  endtask

  // post_falls < 0: close in RESP_WAIT without a response; 0: close in TX_MARK
  task automatic run_txn(input logic [31:0] cmd, input logic [31:0] resp,
                         input int post_falls, input int lo, input bit rst_mid);
    logic [7:0] dq;
    logic       oq;
    bus.spi_cs_n = 1'b0;
    tick(4);
    for (int k = 0; k < MSG_LEN; k++) spi_cycle(cmd[8*(MSG_LEN-1-k) +: 8], lo, (lo < 3) ? 2 : 4, dq, oq);
    tick(2);
    chk("msg_valid", bus.msg_valid, 1'b1);
    chk("msg_data", bus.msg_data, cmd);
    chk("oe_msg", bus.spi_d_oe, 1'b1);
    chk("dout_msg", bus.spi_d_out, BUSY);
    tick(10);
    chk("msg_valid_hold", bus.msg_valid, 1'b1);
    chk("msg_data_hold", bus.msg_data, cmd);
    resp_loaded = 1'b0;
    tx_q.delete();
    spi_cycle(8'($urandom), 4, 4, dq, oq);
    chk("dout_msg_wait", dq, model_fall());
    chk("msg_data_no_capture", bus.msg_data, cmd);
    bus.msg_ready = 1'b1;
    tick(1);
    bus.msg_ready = 1'b0;
    chk("msg_valid_clr", bus.msg_valid, 1'b0);
    for (int k = 0; k < 2; k++) begin
      spi_cycle(8'($urandom), 4, 4, dq, oq);
      chk("dout_resp_wait", dq, model_fall());
      chk("oe_resp_wait", oq, 1'b1);
    end
    if (post_falls >= 0) begin
      bus.resp_valid = 1'b1;
      bus.resp_data = resp;
      tick(1);
      bus.resp_valid = 1'b0;
      resp_loaded = 1'b1;
      tx_q.push_back(MARKER);
      for (int k = 0; k < RESP_LEN; k++) tx_q.push_back(resp[8*(RESP_LEN-1-k) +: 8]);
      for (int k = 0; k < post_falls; k++) begin
        spi_cycle(8'($urandom), 4, 4, dq, oq);
        chk("dout_tx", dq, model_fall());
        chk("oe_tx", oq, 1'b1);
      end
    end
    if (rst_mid) begin
      rst_n = 1'b0;
      #2;
      chk("rst_oe", bus.spi_d_oe, 1'b0);
      chk("rst_msg_valid", bus.msg_valid, 1'b0);
      chk("rst_dout", bus.spi_d_out, BUSY);
      chk("rst_msg_data", bus.msg_data, 32'h0);
      bus.spi_cs_n = 1'b1;
      bus.spi_clk = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(3);
    end else begin
      close_cs((post_falls <= 0) ? 1 : 0, "cs_close");
    end
  endtask

  initial begin
    logic [7:0] dq;
    logic       oq;
    int         a0;
    bus.spi_clk = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.spi_d_in = 8'h00;
    bus.msg_ready = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_data = '0;
    tick(3);
    chk("reset_oe", bus.spi_d_oe, 1'b0);
    chk("reset_dout", bus.spi_d_out, BUSY);
    chk("reset_msg_valid", bus.msg_valid, 1'b0);
    chk("reset_msg_data", bus.msg_data, 32'h0);
    chk("reset_abort", bus.abort, 1'b0);
    rst_n = 1'b1;
    tick(3);

    run_txn(32'h11223344, 32'hDEADBEEF, 6, 4, 1'b0);
    run_txn($urandom, $urandom, 7, 4, 1'b0);
    run_txn($urandom, $urandom, 2, 4, 1'b0);
    run_txn($urandom, $urandom, 0, 4, 1'b0);

    // CS released after two command bytes
    bus.spi_cs_n = 1'b0;
    tick(4);
    for (int k = 0; k < 2; k++) spi_cycle(8'($urandom), 4, 4, dq, oq);
    close_cs(1, "abort_rx");
    run_txn($urandom, $urandom, 6, 4, 1'b0);

    // CS released in RESP_WAIT, then a stray response pulse
    run_txn($urandom, $urandom, -1, 4, 1'b0);
    bus.resp_valid = 1'b1;
    bus.resp_data = $urandom;
    tick(1);
    bus.resp_valid = 1'b0;
    tick(3);
    chk("stray_resp_oe", bus.spi_d_oe, 1'b0);
    run_txn($urandom, $urandom, 6, 4, 1'b0);

    // CS dropped and released with no bytes: no abort
    bus.spi_cs_n = 1'b0;
    tick(4);
    close_cs(0, "cs_no_bytes");

    // Fastest SPI clock: message captured, then released in MSG_WAIT
    bus.spi_cs_n = 1'b0;
    tick(4);
    begin
      logic [31:0] cmd;
      cmd = $urandom;
      for (int k = 0; k < MSG_LEN; k++) spi_cycle(cmd[8*(MSG_LEN-1-k) +: 8], 2, 2, dq, oq);
      tick(2);
      chk("fast_msg_valid", bus.msg_valid, 1'b1);
      chk("fast_msg_data", bus.msg_data, cmd);
    end
    close_cs(1, "abort_msg_wait");

    // Rise coincident with CS release after three bytes must not complete the message
    bus.spi_cs_n = 1'b0;
    tick(4);
    for (int k = 0; k < MSG_LEN - 1; k++) spi_cycle(8'($urandom), 2, 2, dq, oq);
    bus.spi_clk = 1'b0;
    tick(1);
    bus.spi_d_in = 8'($urandom);
    tick(1);
    a0 = abort_cycles;
    bus.spi_clk = 1'b1;
    bus.spi_cs_n = 1'b1;
    tick(6);
    chk("coincide_abort", abort_cycles - a0, 1);
    chk("coincide_msg_valid", bus.msg_valid, 1'b0);
    bus.spi_clk = 1'b0;
    tick(4);

    run_txn($urandom, $urandom, 3, 4, 1'b1);
    run_txn($urandom, $urandom, 6, 4, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
